// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes and the byte-strobe helper for the memory slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } slave_state_e;

  // Byte lanes covered by a transfer of 1<<hsize bytes starting at lane 'offset'.
  function automatic logic [7:0] size_to_strb(logic [2:0] hsize, logic [2:0] offset,
                                              int unsigned nbytes);
    logic [7:0]  strb;
    int unsigned lo, hi;
    lo = 32'(offset);
    hi = lo + (32'd1 << hsize);
    for (int unsigned i = 0; i < 8; i++) begin
      strb[i] = (i < nbytes) && (i >= lo) && (i < hi);
    end
    return strb;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Byte-strobed word storage with a registered read port and write-through forwarding.
module ahb_mem_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WORDS  = 8192,
  parameter int unsigned IDX_W  = 13
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                rd_en,
  input  logic                rd_zero,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data
);
  localparam int unsigned NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_q;

  // Storage is intentionally not reset.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // A read loading on the same edge a write lands sees the new bytes.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wr_strb[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_zero ? '0 : rd_word;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: wait states, two-cycle ERROR responses, RAW forwarding and a mailbox.
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MEM_BYTES    = 65536,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              mailbox_wr_valid,
  output logic [7:0]        mailbox_wr_data
);
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NBYTES);
  localparam int unsigned WORDS  = MEM_BYTES / NBYTES;
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  slave_state_e      state_q;
  logic [3:0]        cnt_q;
  logic              hreadyout_q, hresp_q;
  logic              write_q, mbox_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NBYTES-1:0] strb_q;
  logic              mbox_valid_q;
  logic [7:0]        mbox_data_q;

  logic              accept, accept_slot, is_mbox, acc_err;
  logic [31:0]       offset, align_mask;
  logic [IDX_W-1:0]  acc_idx, rd_idx;
  logic [7:0]        strb_full;
  logic [NBYTES-1:0] acc_strb;
  logic              complete_wr, complete_mbox, rd_en, rd_zero;
  logic              unused_ok;

  assign unused_ok = ^{HBURST, HPROT, strb_full};

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
  always_comb begin
    accept      = HSEL & HREADY & ((HTRANS == TransNonseq) | (HTRANS == TransSeq));
    accept_slot = (state_q == StIdle) | (state_q == StData) | (state_q == StErr2);
    offset      = HADDR - BASE_ADDR;
    align_mask  = (32'd1 << HSIZE) - 32'd1;
    is_mbox     = (HADDR == MAILBOX_ADDR);
    acc_err     = !is_mbox & ((offset >= MEM_BYTES) | (32'(HSIZE) > LANE_W) |
                              (|(HADDR & align_mask)));
    acc_idx     = IDX_W'(offset >> LANE_W);
    strb_full   = size_to_strb(HSIZE, 3'(HADDR[LANE_W-1:0]), NBYTES);
    acc_strb    = strb_full[NBYTES-1:0];
  end

  always_comb begin
    complete_wr   = (state_q == StData) & write_q & ~mbox_q;
    complete_mbox = (state_q == StData) & write_q & mbox_q;
    rd_en         = 1'b0;
    rd_zero       = 1'b0;
    rd_idx        = idx_q;
    if (accept_slot && accept && !HWRITE && (acc_err || (WAIT_STATES == 0))) begin
      rd_en   = 1'b1;
      rd_zero = acc_err | is_mbox;
      rd_idx  = acc_idx;
    end else if ((state_q == StWait) && (cnt_q == '0) && !write_q) begin
      rd_en   = 1'b1;
      rd_zero = mbox_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hreadyout_q  <= 1'b1;
      hresp_q      <= HRESP_OKAY;
      write_q      <= 1'b0;
      mbox_q       <= 1'b0;
      idx_q        <= '0;
      strb_q       <= '0;
      mbox_valid_q <= 1'b0;
      mbox_data_q  <= '0;
    end else begin
      mbox_valid_q <= complete_mbox;
      if (complete_mbox) mbox_data_q <= HWDATA[7:0];
      if (accept_slot && accept) begin
        write_q <= HWRITE;
        mbox_q  <= is_mbox;
        idx_q   <= acc_idx;
        strb_q  <= acc_strb;
        if (acc_err) begin
          state_q     <= StErr1;
          hreadyout_q <= 1'b0;
          hresp_q     <= HRESP_ERROR;
        end else if (WAIT_STATES > 0) begin
          state_q     <= StWait;
          cnt_q       <= 4'(WAIT_STATES - 1);
          hreadyout_q <= 1'b0;
          hresp_q     <= HRESP_OKAY;
        end else begin
          state_q     <= StData;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      end else begin
        case (state_q)
          StWait: begin
            if (cnt_q == '0) begin
              state_q     <= StData;
              hreadyout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          StErr1: begin
            state_q     <= StErr2;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_ERROR;
          end
          default: begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        endcase
      end
    end
  end

  ahb_mem_array #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .IDX_W  (IDX_W)
  ) u_mem (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .rd_en   (rd_en),
    .rd_zero (rd_zero),
    .rd_idx  (rd_idx),
    .wr_en   (complete_wr),
    .wr_idx  (idx_q),
    .wr_strb (strb_q),
    .wr_data (HWDATA),
    .rd_data (HRDATA)
  );

  assign HREADYOUT        = hreadyout_q;
  assign HRESP            = hresp_q;
  assign mailbox_wr_valid = mbox_valid_q;
  assign mailbox_wr_data  = mbox_data_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Two slaves (0 and 3 wait states) on one AHB-Lite bus, checked against a byte-array model.
module tb_ahb_lite_mem_slave;

  localparam int unsigned MEM_BYTES = 1024;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] MBOX      = 32'hD058_0000;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
  } txn_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        hsel = 1'b0;
  logic        HWRITE = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = '0;
  logic [63:0] HWDATA = '0;
  bit          tgt = 1'b0;

  logic        HREADY;
  logic [63:0] rdata0, rdata1, rdata_m;
  logic        ready0, ready1, resp0, resp1, resp_m, mbv0, mbv1, mbv_m;
  logic [7:0]  mbd0, mbd1, mbd_m;

  assign HREADY  = tgt ? ready1 : ready0;
  assign rdata_m = tgt ? rdata1 : rdata0;
  assign resp_m  = tgt ? resp1 : resp0;
  assign mbv_m   = tgt ? mbv1 : mbv0;
  assign mbd_m   = tgt ? mbd1 : mbd0;

  txn_t        q[$];
  byte unsigned ref_mem [2][MEM_BYTES];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] last_rdata = '0;

  always #5 HCLK = ~HCLK;

  ahb_lite_mem_slave #(
    .DATA_W(64), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE), .WAIT_STATES(0), .MAILBOX_ADDR(MBOX)
  ) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & ~tgt), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HREADY(HREADY),
    .HWDATA(HWDATA), .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0),
    .mailbox_wr_valid(mbv0), .mailbox_wr_data(mbd0)
  );

  ahb_lite_mem_slave #(
    .DATA_W(64), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE), .WAIT_STATES(3), .MAILBOX_ADDR(MBOX)
  ) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & tgt), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HREADY(HREADY),
    .HWDATA(HWDATA), .HRDATA(rdata1), .HREADYOUT(ready1), .HRESP(resp1),
    .mailbox_wr_valid(mbv1), .mailbox_wr_data(mbd1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: error rules, wait counts and byte-addressed storage.
  function automatic bit ref_err(txn_t t);
    int unsigned off;
    if (t.addr == MBOX) return 1'b0;
    off = t.addr - BASE;
    if (off >= MEM_BYTES) return 1'b1;
    if (t.size > 3) return 1'b1;
    if ((t.addr % (32'd1 << t.size)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ws_of(input bit tg);
    return tg ? 3 : 0;
  endfunction

  function automatic logic [63:0] ref_read(input bit tg, input logic [31:0] addr);
    int          base;
    logic [63:0] v;
    base = int'((addr - BASE) / 8 * 8);
    for (int k = 0; k < 8; k++) v[8*k +: 8] = ref_mem[tg][base + k];
    return v;
  endfunction

  task automatic ref_write(input bit tg, input txn_t t);
    int off;
    off = int'(t.addr - BASE);
    for (int k = 0; k < (1 << t.size); k++) ref_mem[tg][off + k] = t.wdata[8*((off + k) % 8) +: 8];
  endtask

  task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] wdata);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
    q.push_back(t);
  endtask

  task automatic drive_addr(input int idx);
    if (idx < q.size()) begin
      hsel = 1'b1; HTRANS = 2'b10; HADDR = q[idx].addr; HWRITE = q[idx].wr; HSIZE = q[idx].size;
    end else begin
      hsel = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = '0;
    end
  endtask

  // Pipelined master: address phase of one transfer overlaps the data phase of the previous.
  task automatic run_seq(input bit tg);
    int          ai = 0, di = -1, lows = 0, cyc = 0;
    bit          rdy, mb_exp = 1'b0, t_err, t_mb;
    logic [7:0]  mb_data = '0;
    logic [63:0] exp_rd;
    tgt = tg;
    drive_addr(0);
    while ((ai < q.size() || di >= 0 || mb_exp) && cyc < 1000) begin
      @(negedge HCLK);
      cyc++;
      check_eq("mb_valid", 64'(mbv_m), 64'(mb_exp));
      if (mb_exp) check_eq("mb_data", 64'(mbd_m), 64'(mb_data));
      mb_exp = 1'b0;
      rdy = HREADY;
      if (di >= 0) begin
        t_err = ref_err(q[di]);
        t_mb  = (q[di].addr == MBOX);
        if (!rdy) begin
          lows++;
          check_eq("wait_resp", 64'(resp_m), 64'(t_err));
        end else begin
          check_eq("wait_cycles", 64'(lows), 64'(t_err ? 1 : ws_of(tg)));
          check_eq("resp", 64'(resp_m), 64'(t_err));
          if (!q[di].wr) begin
            exp_rd = (t_err || t_mb) ? 64'h0 : ref_read(tg, q[di].addr);
            check_eq("rdata", rdata_m, exp_rd);
            last_rdata = rdata_m;
          end else if (t_mb) begin
            mb_exp  = 1'b1;
            mb_data = q[di].wdata[7:0];
          end else if (!t_err) begin
            ref_write(tg, q[di]);
          end
        end
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        di = (ai < q.size()) ? ai : -1;
        if (ai < q.size()) ai++;
        lows = 0;
        drive_addr(ai);
        HWDATA = (di >= 0) ? q[di].wdata : 64'h0;
      end
    end
    check_eq("seq_done", 64'(cyc < 1000), 64'd1);
    q.delete();
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned kind = $urandom_range(0, 15);
      logic [2:0]  sz   = 3'($urandom_range(0, 3));
      logic [31:0] a    = 32'h100 + 32'($urandom_range(0, 7)) * 8 +
                          ((32'($urandom_range(0, 7)) >> sz) << sz);
      logic [63:0] d    = {$urandom(), $urandom()};
      logic        wr   = 1'($urandom_range(0, 1));
      case (kind)
        0: a = MBOX;
        1: a = a + MEM_BYTES;
        2: sz = 3'($urandom_range(4, 7));
        3: begin
          sz = 3'($urandom_range(1, 3));
          a  = a | 32'd1;
        end
        default: ;
      endcase
      push(wr, a, sz, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    check_eq("rst_ready0", 64'(ready0), 64'd1);
    check_eq("rst_resp0", 64'(resp0), 64'd0);
    check_eq("rst_rdata0", rdata0, 64'd0);
    check_eq("rst_mbv0", 64'(mbv0), 64'd0);
    check_eq("rst_ready1", 64'(ready1), 64'd1);
    check_eq("rst_rdata1", rdata1, 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    push(1'b1, 32'h10, 3'd3, 64'h1122334455667788);
    push(1'b0, 32'h10, 3'd3, 64'h0);
    run_seq(1'b0);
    check_eq("dir_fwd", last_rdata, 64'h1122334455667788);

    push(1'b1, 32'h03, 3'd0, 64'h0000_0000_AA00_0000);
    push(1'b0, 32'h00, 3'd3, 64'h0);
    run_seq(1'b0);
    check_eq("dir_byte", last_rdata, 64'h0000_0000_AA00_0000);

    push(1'b1, BASE + MEM_BYTES, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    push(1'b0, 32'h00, 3'd3, 64'h0);
    push(1'b0, 32'h02, 3'd2, 64'h0);
    push(1'b1, MBOX, 3'd2, 64'h0000_0000_0000_00FF);
    run_seq(1'b0);
    check_eq("dir_oob_keep", last_rdata, 64'h0);

    push(1'b1, 32'h20, 3'd3, 64'h0123_4567_89AB_CDEF);
    push(1'b0, 32'h20, 3'd3, 64'h0);
    push(1'b1, 32'h40, 3'd3, 64'hCAFE_F00D_1234_5678);
    run_seq(1'b1);
    check_eq("dir_ws_data", last_rdata, 64'h0123_4567_89AB_CDEF);

    // Reset while a write to 0x40 sits in its wait states: the write must be lost.
    HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd3; hsel = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK);
    #1;
    hsel = 1'b0; HTRANS = 2'b00; HWDATA = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge HCLK);
    #1;
    check_eq("wait_pre_rst", 64'(ready1), 64'd0);
    HRESETn = 1'b0;
    #1;
    check_eq("rst_async_ready", 64'(ready1), 64'd1);
    check_eq("rst_async_resp", 64'(resp1), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    push(1'b0, 32'h40, 3'd3, 64'h0);
    run_seq(1'b1);
    check_eq("rst_old_data", last_rdata, 64'hCAFE_F00D_1234_5678);

    for (int b = 0; b < 6; b++) begin
      push_random(16);
      run_seq(1'(b % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
